// File: rtl/soc_reset_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_reset_seq: clean active-low SoC reset from PLL lock and debounced button,
// with last-cause record. Optional watchdog built with SOC_RESET_WDT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module soc_reset_seq #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int HOLD_CYCLES     = 256,
   parameter int WDT_CYCLES      = 16777216
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       pll_locked_i,
   input  logic       button_ni,
   input  logic       wdt_kick_i,
   output logic       soc_reset_no,
   output logic [1:0] state_o,
   output logic [1:0] reset_cause_o
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR    = 2'b00;
   localparam logic [1:0] CAUSE_BUTTON = 2'b01;
   localparam logic [1:0] CAUSE_LOCK   = 2'b10;
   localparam logic [1:0] CAUSE_WDT    = 2'b11;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'b00,
      ST_HOLD      = 2'b01,
      ST_RUN       = 2'b10
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             cause_q, cause_d;
   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
   logic                   btn_db_q, btn_db_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                   lock_s, btn_s;
   logic                   wdt_expire;

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign btn_s  = btn_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_WAIT_LOCK;
         cause_q     <= CAUSE_POR;
         lock_sync_q <= '0;
         btn_sync_q  <= '1;
         btn_db_q    <= 1'b1;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         lock_sync_q <= lock_sync_d;
         btn_sync_q  <= btn_sync_d;
         btn_db_q    <= btn_db_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], button_ni};
      btn_db_d    = btn_db_q;
      db_cnt_d    = '0;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      hold_cnt_d = '0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (lock_s && btn_db_q) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // An aborted hold leaves the cause alone: the sequence never completed.
            if (!lock_s || !btn_db_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cause_d = CAUSE_LOCK;
            end else if (!btn_db_q) begin
               state_d = ST_WAIT_LOCK;
               cause_d = CAUSE_BUTTON;
            end else if (wdt_expire) begin
               state_d = ST_WAIT_LOCK;
               cause_d = CAUSE_WDT;
            end
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

`ifdef SOC_RESET_WDT_EN
   localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end

   // Held at zero outside RUN, so every RUN entry starts a fresh timeout.
   always_comb begin
      wdt_cnt_d  = '0;
      wdt_expire = 1'b0;
      if (state_q == ST_RUN && !wdt_kick_i) begin
         if (wdt_cnt_q == WDT_LAST) begin
            wdt_expire = 1'b1;
         end else begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
         end
      end
   end
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick_i ^ (WDT_CYCLES > 0);
   assign wdt_expire = 1'b0;
`endif

   assign soc_reset_no  = (state_q == ST_RUN);
   assign state_o       = state_q;
   assign reset_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_reset_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_soc_reset_seq: directed table, corner sequences and random stimulus
// against a cycle-stamp reference model. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_soc_reset_seq;

   localparam int SS   = 2;
   localparam int DB   = 8;
   localparam int HOLD = 16;
   localparam int WDT  = 32;
`ifdef SOC_RESET_WDT_EN
   localparam bit WDT_EN = 1'b1;
`else
   localparam bit WDT_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       reset_i, pll_locked_i, button_ni, wdt_kick_i;
   logic       soc_reset_no;
   logic [1:0] state_o, reset_cause_o;
   logic [4:0] dut_vec;

   int checks = 0;
   int errors = 0;

   soc_reset_seq #(
      .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .WDT_CYCLES(WDT)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .pll_locked_i(pll_locked_i),
      .button_ni(button_ni), .wdt_kick_i(wdt_kick_i), .soc_reset_no(soc_reset_no),
      .state_o(state_o), .reset_cause_o(reset_cause_o)
   );

   always #5 clk_i = ~clk_i;
   assign dut_vec = {soc_reset_no, state_o, reset_cause_o};

   // Reference model: pin delay lines, a mismatch run length and cycle stamps.
   logic       lock_pipe [0:SS-1];
   logic       btn_pipe  [0:SS-1];
   logic       m_db;
   int         m_run;
   logic [1:0] m_state;
   logic [1:0] m_cause;
   int         cyc, hold_start, last_kick;

   task automatic model_reset();
      for (int i = 0; i < SS; i++) begin
         lock_pipe[i] = 1'b0;
         btn_pipe[i]  = 1'b1;
      end
      m_db = 1'b1; m_run = 0; m_state = 2'd0; m_cause = 2'd0;
      cyc = 0; hold_start = 0; last_kick = 0;
   endtask

   task automatic model_step();
      logic ls, bs;
      ls = lock_pipe[SS-1];
      bs = btn_pipe[SS-1];
      case (m_state)
         2'd0: if (ls && m_db) begin m_state = 2'd1; hold_start = cyc; end
         2'd1: begin
            if (!ls || !m_db) m_state = 2'd0;
            else if (cyc - hold_start == HOLD) begin m_state = 2'd2; last_kick = cyc; end
         end
         default: begin
            if (!ls) begin m_state = 2'd0; m_cause = 2'd2; end
            else if (!m_db) begin m_state = 2'd0; m_cause = 2'd1; end
            else if (WDT_EN && !wdt_kick_i && cyc - last_kick == WDT) begin
               m_state = 2'd0; m_cause = 2'd3;
            end else if (wdt_kick_i) last_kick = cyc;
         end
      endcase
      if (bs != m_db) begin
         m_run++;
         if (m_run == DB) begin m_db = bs; m_run = 0; end
      end else m_run = 0;
      for (int i = SS - 1; i > 0; i--) begin
         lock_pipe[i] = lock_pipe[i-1];
         btn_pipe[i]  = btn_pipe[i-1];
      end
      lock_pipe[0] = pll_locked_i;
      btn_pipe[0]  = button_ni;
      cyc++;
   endtask

   function automatic logic [4:0] model_vec();
      return {m_state == 2'd2, m_state, m_cause};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got rst_n=%b state=%b cause=%b, expected rst_n=%b state=%b cause=%b",
                  name, $time, act[4], act[3:2], act[1:0], exp[4], exp[3:2], exp[1:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (!reset_i) model_step();
      #1;
   endtask

   task automatic tick_chk(input string name);
      tick();
      check(name, dut_vec, model_vec());
   endtask

   task automatic wait_run(input string name);
      int n;
      n = 0;
      while (m_state != 2'd2 && n < 300) begin
         tick_chk(name);
         n++;
      end
      if (m_state != 2'd2) begin
         checks++;
         errors++;
         $display("FAIL %s: RUN not reached within 300 cycles, state=%b", name, state_o);
      end
   endtask

   typedef struct {
      logic       lock;
      logic       btn;
      int         n;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic lock, input logic btn, input int n, input logic [4:0] exp);
      vec_t v;
      v.lock = lock; v.btn = btn; v.n = n; v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      reset_i = 1'b1; pll_locked_i = 1'b1; button_ni = 1'b1; wdt_kick_i = 1'b1;
      model_reset();
      #1;
      check("reset_state", dut_vec, 5'b0_00_00);

      // power-up: RUN on edge 19 after deassert
      add(1, 1, 2,  5'b0_00_00); add(1, 1, 1,  5'b0_01_00);
      add(1, 1, 15, 5'b0_01_00); add(1, 1, 1,  5'b1_10_00);
      // one-cycle lock drop in RUN, then relock
      add(0, 1, 1,  5'b1_10_00); add(1, 1, 1,  5'b1_10_00);
      add(1, 1, 1,  5'b0_00_10); add(1, 1, 1,  5'b0_01_10);
      add(1, 1, 15, 5'b0_01_10); add(1, 1, 1,  5'b1_10_10);
      // 3-cycle button glitch is filtered
      add(1, 0, 3,  5'b1_10_10); add(1, 1, 20, 5'b1_10_10);
      // held button
      add(1, 0, 10, 5'b1_10_10); add(1, 0, 1,  5'b0_00_01);
      add(1, 0, 9,  5'b0_00_01);
      // release, then lock drop at hold count 10 restarts the full hold
      add(1, 1, 10, 5'b0_00_01); add(1, 1, 1,  5'b0_01_01);
      add(1, 1, 10, 5'b0_01_01); add(0, 1, 1,  5'b0_01_01);
      add(1, 1, 1,  5'b0_01_01); add(1, 1, 1,  5'b0_00_01);
      add(1, 1, 1,  5'b0_01_01); add(1, 1, 15, 5'b0_01_01);
      add(1, 1, 1,  5'b1_10_01);

      tick(); tick();
      #2 reset_i = 1'b0;
      foreach (tbl[i]) begin
         pll_locked_i = tbl[i].lock;
         button_ni    = tbl[i].btn;
         repeat (tbl[i].n) tick();
         check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
      end

      // watchdog: periodic kicks keep RUN, silence expires it only when built
      wdt_kick_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         repeat (19) tick_chk("wdt_kicked");
         wdt_kick_i = 1'b1;
         tick_chk("wdt_kick");
         wdt_kick_i = 1'b0;
         check("wdt_still_run", dut_vec, 5'b1_10_01);
      end
      repeat (31) tick_chk("wdt_silent");
      check("wdt_before_expiry", dut_vec, 5'b1_10_01);
      tick_chk("wdt_expiry_edge");
      check("wdt_expiry", dut_vec, WDT_EN ? 5'b0_00_11 : 5'b1_10_01);
      wdt_kick_i = 1'b1;
      wait_run("wdt_recover");

      // lock loss and debounced button reach the FSM on the same edge
      button_ni = 1'b0;
      repeat (8) tick_chk("prio_btn");
      pll_locked_i = 1'b0;
      repeat (2) tick_chk("prio_wait");
      check("prio_before", dut_vec, 5'b1_10_01);
      tick_chk("prio_edge");
      check("prio_lock_wins", dut_vec, 5'b0_00_10);
      pll_locked_i = 1'b1; button_ni = 1'b1;
      wait_run("prio_recover");

      for (int seg = 0; seg < 60; seg++) begin
         int kind, len;
         kind = $urandom_range(0, 9);
         if (kind <= 2) begin
            len = $urandom_range(1, 6);
            pll_locked_i = 1'b0;
         end else if (kind <= 5) begin
            len = $urandom_range(1, 25);
            button_ni = 1'b0;
         end else begin
            len = $urandom_range(20, 80);
         end
         for (int c = 0; c < len; c++) begin
            wdt_kick_i = ($urandom_range(0, 7) == 0);
            tick_chk("random");
         end
         pll_locked_i = 1'b1; button_ni = 1'b1;
         repeat ($urandom_range(0, 30)) begin
            wdt_kick_i = ($urandom_range(0, 7) == 0);
            tick_chk("random_idle");
         end
      end

      // asynchronous reset between edges while running
      wdt_kick_i = 1'b1;
      wait_run("pre_async");
      #2 reset_i = 1'b1;
      #1;
      check("async_reset_no_clock", dut_vec, 5'b0_00_00);
      model_reset();
      tick();
      check("async_reset_held", dut_vec, 5'b0_00_00);
      #3 reset_i = 1'b0;
      repeat (18) tick_chk("post_reset");
      check("post_reset_edge18", dut_vec, 5'b0_01_00);
      tick_chk("post_reset");
      check("post_reset_edge19", dut_vec, 5'b1_10_00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
